// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the fetch-stage PC -> instruction-memory interface.
package mips_fetch_pkg;

  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT  = 32'h0000_0000;
  localparam int          ADDR_W            = 32;
  localparam int          INSTR_W           = 32;
  localparam int          CNT_W             = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/imem_rom.sv
// Word array with synchronous write and registered read; a same-cycle write/read of one index returns the old word.
module imem_rom #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [WIDTH-1:0]         wdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) mem_q[widx] <= wdata;
    if (re) rdata_q <= mem_q[ridx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch responder: one outstanding request, response LATENCY+1 cycles after accept as a one-cycle pulse.
// req_ready is high only while idle; a flush kills a waiting request or NOPs the response being presented.
module imem_fetch_responder #(
  parameter logic [31:0] TEXT_BASE = mips_fetch_pkg::TEXT_BASE_DEFAULT,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] NOP_WORD  = mips_fetch_pkg::NOP_WORD_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     resp_valid,
  output logic [31:0]              resp_instr,
  output logic [31:0]              resp_addr,
  output logic                     resp_fault,
  output logic                     pc_advance,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_widx,
  input  logic [31:0]              prog_wdata
);
  import mips_fetch_pkg::*;

  localparam int          AW     = $clog2(DEPTH);
  localparam int          LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [31:0] SPAN   = 32'(DEPTH) << 2;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [AW-1:0]      idx_q;
  logic               fault_q;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic               resp_fault_q;
  logic [ADDR_W-1:0]  resp_addr_q;

  logic [ADDR_W-1:0]  offset;
  logic [AW-1:0]      req_idx;
  logic               req_fault;
  logic               accept;
  logic               wait_done;
  logic               rom_re;
  logic [AW-1:0]      rom_ridx;
  logic [INSTR_W-1:0] rom_rdata;

  // Subtraction wraps mod 2^32 for the index; the range test below never wraps.
  assign offset    = req_addr - TEXT_BASE;
  assign req_idx   = offset[AW+1:2];
  assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr < TEXT_BASE) || (offset >= SPAN);

  assign accept    = req_ready_q && req_valid && !flush;
  assign wait_done = (state_q == WAIT) && (cnt_q == '0) && !flush;

  // The ROM read lands on the edge that enters RESP, so the word is ready for the pulse.
  assign rom_ridx = (state_q == IDLE) ? req_idx : idx_q;
  assign rom_re   = (accept && (LATENCY == 0) && !req_fault) || (wait_done && !fault_q);

  imem_rom #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_rom (
    .clock (clock),
    .re    (rom_re),
    .ridx  (rom_ridx),
    .rdata (rom_rdata),
    .we    (prog_we),
    .widx  (prog_widx),
    .wdata (prog_wdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      idx_q        <= '0;
      fault_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_addr_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q      <= req_addr;
            idx_q       <= req_idx;
            fault_q     <= req_fault;
            req_ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= req_fault;
              resp_addr_q  <= req_addr;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LAT_M1);
            end
          end
        end
        WAIT: begin
          if (flush) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end else if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_fault_q <= fault_q;
            resp_addr_q  <= addr_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_addr  = resp_addr_q;
  assign resp_fault = resp_fault_q;
  assign resp_instr = (resp_valid_q && !resp_fault_q && !flush) ? rom_rdata : NOP_WORD;
  assign pc_advance = resp_valid_q && !resp_fault_q && !flush;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: LATENCY=2 instance with scoreboard, plus a LATENCY=0 instance.
module tb_imem_fetch_responder;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        req_valid, req_ready, flush, resp_valid, resp_fault, pc_advance, prog_we;
  logic [31:0] req_addr, resp_instr, resp_addr, prog_wdata;
  logic [9:0]  prog_widx;

  logic        req_valid0, req_ready0, flush0, resp_valid0, resp_fault0, pc_advance0, prog_we0;
  logic [31:0] req_addr0, resp_instr0, resp_addr0, prog_wdata0;
  logic [9:0]  prog_widx0;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  logic [31:0] model [1024];

  always #5 clock = ~clock;

  imem_fetch_responder #(.TEXT_BASE(BASE), .DEPTH(1024), .LATENCY(LAT), .NOP_WORD(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .flush(flush), .resp_valid(resp_valid), .resp_instr(resp_instr),
    .resp_addr(resp_addr), .resp_fault(resp_fault), .pc_advance(pc_advance),
    .prog_we(prog_we), .prog_widx(prog_widx), .prog_wdata(prog_wdata)
  );

  imem_fetch_responder #(.TEXT_BASE(BASE), .DEPTH(1024), .LATENCY(0), .NOP_WORD(32'h0)) dut0 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid0), .req_addr(req_addr0),
    .req_ready(req_ready0), .flush(flush0), .resp_valid(resp_valid0), .resp_instr(resp_instr0),
    .resp_addr(resp_addr0), .resp_fault(resp_fault0), .pc_advance(pc_advance0),
    .prog_we(prog_we0), .prog_widx(prog_widx0), .prog_wdata(prog_wdata0)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_exp(input logic [31:0] a);
    exp_t        e;
    logic [31:0] off;
    off     = a - BASE;
    e.addr  = a;
    e.fault = (a[1:0] != 2'b00) || (a < BASE) || (off >= 32'h0000_1000);
    e.instr = e.fault ? 32'h0 : model[off[11:2]];
    return e;
  endfunction

  task automatic load(input logic [9:0] idx, input logic [31:0] w);
    prog_we = 1'b1; prog_widx = idx; prog_wdata = w;
    model[idx] = w;
    step();
    prog_we = 1'b0;
  endtask

  task automatic compare_resp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_addr"},  resp_addr,  e.addr);
      check({tag, "_instr"}, resp_instr, e.instr);
      check({tag, "_fault"}, 32'(resp_fault), 32'(e.fault));
      check({tag, "_pcadv"}, 32'(pc_advance), 32'(!e.fault));
    end
  endtask

  // Issue one request from idle, measure latency, compare the response and its single-cycle width.
  task automatic fetch(input logic [31:0] a, input string tag);
    int lat;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a;
    sb.push_back(model_exp(a));
    step();
    req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (resp_valid === 1'b1) begin
        lat = i;
        break;
      end
      step();
    end
    check({tag, "_lat"}, 32'(lat), 32'(LAT + 1));
    if (lat != 0) compare_resp(tag);
    else void'(sb.pop_front());
    step();
    check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_acc, n_resp, pulses;
    int          acc_cyc [2];
    int          resp_cyc [2];
    logic [31:0] a_list [2];

    reset_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; flush = 1'b0; prog_we = 1'b0; prog_widx = '0; prog_wdata = '0;
    req_valid0 = 1'b0; req_addr0 = '0; flush0 = 1'b0; prog_we0 = 1'b0; prog_widx0 = '0; prog_wdata0 = '0;
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_instr", resp_instr, 32'h0);
    check("rst_addr",  resp_addr, 32'h0);
    check("rst_fault", 32'(resp_fault), 32'd0);
    check("rst_pcadv", 32'(pc_advance), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Test 1: basic fetch with exact cycle-by-cycle handshake
    load(10'd0, 32'h2408_0005);
    req_valid = 1'b1; req_addr = BASE;
    sb.push_back(model_exp(BASE));
    step();
    req_valid = 1'b0;
    check("t1_c2_ready", 32'(req_ready), 32'd0);
    check("t1_c2_valid", 32'(resp_valid), 32'd0);
    step();
    check("t1_c3_ready", 32'(req_ready), 32'd0);
    check("t1_c3_valid", 32'(resp_valid), 32'd0);
    step();
    check("t1_c4_valid", 32'(resp_valid), 32'd1);
    check("t1_c4_ready", 32'(req_ready), 32'd0);
    compare_resp("t1");
    step();
    check("t1_c5_valid", 32'(resp_valid), 32'd0);
    check("t1_c5_ready", 32'(req_ready), 32'd1);

    // Test 2: back-to-back with req_valid held
    load(10'd1, 32'h2409_0007);
    a_list[0] = BASE; a_list[1] = BASE + 32'd4;
    n_acc = 0; n_resp = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; resp_cyc[0] = 0; resp_cyc[1] = 0;
    req_valid = 1'b1; req_addr = a_list[0];
    for (int c = 0; c < 16; c++) begin
      if (req_ready === 1'b1 && req_valid === 1'b1 && n_acc < 2) begin
        sb.push_back(model_exp(req_addr));
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      step();
      if (n_acc == 1) req_addr = a_list[1];
      if (n_acc == 2) req_valid = 1'b0;
      if (resp_valid === 1'b1) begin
        if (n_resp < 2) resp_cyc[n_resp] = c + 1;
        n_resp++;
        compare_resp("t2");
      end
    end
    req_valid = 1'b0;
    check("t2_n_resp", 32'(n_resp), 32'd2);
    check("t2_lat", 32'(resp_cyc[0] - acc_cyc[0]), 32'(LAT + 1));
    check("t2_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(LAT + 2));

    // Test 3: faults and the in-range boundary word
    load(10'd1023, 32'h1234_5678);
    fetch(32'h0040_0002, "t3_misal");
    fetch(32'h003F_FFFC, "t3_below");
    fetch(32'h0040_1000, "t3_above");
    fetch(32'h0040_0FFC, "t3_last");

    // Test 4: flush one cycle after accept, then flush while idle
    req_valid = 1'b1; req_addr = BASE + 32'd4;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_ready", 32'(req_ready), 32'd1);
    check("t4_valid", 32'(resp_valid), 32'd0);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (resp_valid !== 1'b0) pulses++;
    end
    check("t4_no_resp", 32'(pulses), 32'd0);
    fetch(BASE + 32'd4, "t4_after");
    req_valid = 1'b1; req_addr = BASE; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    check("t4_idle_flush", 32'(req_ready), 32'd1);

    // Flush during the response cycle: pulse stays, instruction is killed
    req_valid = 1'b1; req_addr = BASE;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("tf_valid", 32'(resp_valid), 32'd1);
    flush = 1'b1;
    #1;
    check("tf_instr", resp_instr, 32'h0);
    check("tf_pcadv", 32'(pc_advance), 32'd0);
    check("tf_valid_kept", 32'(resp_valid), 32'd1);
    step();
    flush = 1'b0;
    check("tf_ready", 32'(req_ready), 32'd1);

    // Test 5: asynchronous reset mid-WAIT
    req_valid = 1'b1; req_addr = BASE;
    step();
    req_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_ready", 32'(req_ready), 32'd1);
    check("t5_valid", 32'(resp_valid), 32'd0);
    step();
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (resp_valid !== 1'b0) pulses++;
    end
    check("t5_no_resp", 32'(pulses), 32'd0);

    // Test 6: LATENCY=0 instance, same-cycle write and fetch of one index
    prog_we0 = 1'b1; prog_widx0 = 10'd5; prog_wdata0 = 32'hAAAA_0001;
    step();
    prog_we0 = 1'b0;
    check("t6_ready", 32'(req_ready0), 32'd1);
    req_valid0 = 1'b1; req_addr0 = BASE + 32'h14;
    prog_we0 = 1'b1; prog_wdata0 = 32'hBBBB_0002;
    step();
    req_valid0 = 1'b0; prog_we0 = 1'b0;
    check("t6_valid", 32'(resp_valid0), 32'd1);
    check("t6_old_word", resp_instr0, 32'hAAAA_0001);
    check("t6_addr", resp_addr0, BASE + 32'h14);
    check("t6_pcadv", 32'(pc_advance0), 32'd1);
    check("t6_busy", 32'(req_ready0), 32'd0);
    step();
    check("t6_pulse", 32'(resp_valid0), 32'd0);
    check("t6_ready2", 32'(req_ready0), 32'd1);
    req_valid0 = 1'b1;
    step();
    req_valid0 = 1'b0;
    check("t6_new_word", resp_instr0, 32'hBBBB_0002);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
